// File: rtl/vga_frame_reader_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and helpers for the frame reader.
// Timing constants match the 640x480 driver this block feeds.
package vga_frame_reader_pkg;

  localparam int SCREEN_X    = 640;
  localparam int SCREEN_Y    = 480;
  localparam int H_PERIOD    = 801;
  localparam int V_PERIOD    = 526;
  localparam int RGB_W       = 12;
  localparam logic [RGB_W-1:0] BLACK       = 12'h000;
  localparam logic [RGB_W-1:0] CLEAR_COLOR = 12'h000;

  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = SCREEN_X >> SCALE_SHIFT;
  localparam int FB_H        = SCREEN_Y >> SCALE_SHIFT;
  localparam int FB_DEPTH    = FB_W * FB_H;
  localparam int ADDR_W      = $clog2(FB_DEPTH);
  localparam int FB_X_W      = 8;
  localparam int FB_Y_W      = 7;
  localparam int POS_X_W     = 10;
  localparam int POS_Y_W     = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } wr_state_e;

  // row*160 + col as (row<<7)+(row<<5)+col, so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [FB_Y_W-1:0] row,
                                                input logic [FB_X_W-1:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 7) + (r << 5) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_frame_reader_frame_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port, read-first.
// One cycle read latency; neither port ever stalls.
module frame_ram #(
  parameter int DEPTH = 19200,
  parameter int WIDTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_dat_q;

  // Read and write share one block so a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/vga_frame_reader.sv
// Scans a 160x120 frame buffer out to the VGA driver with 4x pixel replication (2-cycle read
// pipeline, fed two positions ahead); drawing writes use valid/ready and stall only during clear.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [POS_X_W-1:0] posX,
  input  logic [POS_Y_W-1:0] posY,
  output logic [RGB_W-1:0]   pixel_out,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [FB_X_W-1:0]  wr_x,
  input  logic [FB_Y_W-1:0]  wr_y,
  input  logic [RGB_W-1:0]   wr_data,
  input  logic               clear_req,
  output logic               busy,
  output logic               drop_err
);

  logic [POS_X_W:0]   lx_raw;
  logic [POS_X_W-1:0] lx;
  logic [POS_Y_W-1:0] ly;
  logic               vis_d, vis_q;
  logic [ADDR_W-1:0]  rd_addr;
  logic [RGB_W-1:0]   ram_rd_dat;
  logic [RGB_W-1:0]   pixel_d, pixel_q;

  wr_state_e          state_d, state_q;
  logic [ADDR_W-1:0]  clr_cnt_d, clr_cnt_q;
  logic               drop_err_d, drop_err_q;
  logic               ram_wr_en;
  logic [ADDR_W-1:0]  ram_wr_addr;
  logic [RGB_W-1:0]   ram_wr_dat;
  logic               wr_rdy;
  logic               clr_busy;
  logic               wr_in_range;

  // Look two positions ahead so the RAM and output registers line up with the driver.
  always_comb begin
    lx_raw  = {1'b0, posX} + (POS_X_W + 1)'(2);
    lx      = lx_raw[POS_X_W-1:0];
    ly      = posY;
    if (lx_raw >= (POS_X_W + 1)'(H_PERIOD)) begin
      lx = POS_X_W'(lx_raw - (POS_X_W + 1)'(H_PERIOD));
      ly = (posY == POS_Y_W'(V_PERIOD - 1)) ? '0 : posY + POS_Y_W'(1);
    end
    vis_d   = (lx < POS_X_W'(SCREEN_X)) && (ly < POS_Y_W'(SCREEN_Y));
    rd_addr = vis_d ? fb_addr(ly[SCALE_SHIFT +: FB_Y_W], lx[SCALE_SHIFT +: FB_X_W]) : '0;
  end

  always_comb begin
    pixel_d = vis_q ? ram_rd_dat : BLACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vis_q   <= 1'b0;
      pixel_q <= BLACK;
    end else begin
      vis_q   <= vis_d;
      pixel_q <= pixel_d;
    end
  end

  assign wr_in_range = (wr_x < FB_X_W'(FB_W)) && (wr_y < FB_Y_W'(FB_H));

  // Write port owner: drawing engine in IDLE, clear counter in CLEAR.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    drop_err_d  = drop_err_q;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_dat  = BLACK;
    wr_rdy      = 1'b0;
    clr_busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_rdy = !rst;
        if (wr_valid && wr_rdy) begin
          if (wr_in_range) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = fb_addr(wr_y, wr_x);
            ram_wr_dat  = wr_data;
          end else begin
            drop_err_d = 1'b1;
          end
        end
        if (clear_req) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr_busy    = 1'b1;
        ram_wr_en   = !rst;
        ram_wr_addr = clr_cnt_q;
        ram_wr_dat  = CLEAR_COLOR;
        if (clr_cnt_q == ADDR_W'(FB_DEPTH - 1)) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      drop_err_q <= drop_err_d;
    end
  end

  frame_ram #(
    .DEPTH (FB_DEPTH),
    .WIDTH (RGB_W),
    .AW    (ADDR_W)
  ) u_frame_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_dat  (ram_wr_dat),
    .rd_addr (rd_addr),
    .rd_dat  (ram_rd_dat)
  );

  assign pixel_out = pixel_q;
  assign wr_ready  = wr_rdy;
  assign busy      = clr_busy;
  assign drop_err  = drop_err_q;

endmodule
